// File: rtl/wb_pkg.sv
// Shared widths and the writeback entry record used by the queue and its FIFO.
package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int POS_W  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [POS_W-1:0]  pos;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle for the writeback queue: two producer handshakes, the
// register-file write port, the hazard query and the occupancy readout.
interface wb_queue_if #(
  parameter int DEPTH = 4
) ();
  import wb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              alu_valid_i;
  logic              alu_ready_o;
  logic [ADDR_W-1:0] alu_addr_i;
  logic [DATA_W-1:0] alu_data_i;
  logic [POS_W-1:0]  alu_pos_i;

  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic [POS_W-1:0]  ld_pos_i;

  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic [POS_W-1:0]  is_pos_o;
  logic              RegWrite_o;

  logic [ADDR_W-1:0] chk_addr_i;
  logic              chk_pend_o;
  logic [CNT_W-1:0]  count_o;

  // Queue side
  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i, alu_pos_i,
    input  ld_valid_i, ld_addr_i, ld_data_i, ld_pos_i,
    input  chk_addr_i,
    output alu_ready_o, ld_ready_o,
    output RDaddr_o, RDdata_o, is_pos_o, RegWrite_o,
    output chk_pend_o, count_o
  );

  // Producer / register-file side
  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i, alu_pos_i,
    output ld_valid_i, ld_addr_i, ld_data_i, ld_pos_i,
    output chk_addr_i,
    input  alu_ready_o, ld_ready_o,
    input  RDaddr_o, RDdata_o, is_pos_o, RegWrite_o,
    input  chk_pend_o, count_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO of writeback entries. Exposes the raw storage and
// a per-slot occupancy mask so the owner can search pending entries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        wdata_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output wb_entry_t        mem_o [DEPTH],
  output logic [DEPTH-1:0] occ_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];

  // Pointer and occupancy next state; power-of-two depth makes wrap free
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written at the tail; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= wdata_i;
  end

  // A slot is live when its distance from the head is below the occupancy
  for (genvar g = 0; g < DEPTH; g++) begin : g_occ
    logic [PTR_W-1:0] off;
    assign off      = PTR_W'(g) - head_q;
    assign occ_o[g] = ({1'b0, off} < count_q);
  end

  assign head_o  = mem_q[head_q];
  assign mem_o   = mem_q;
  assign count_o = count_q;

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: arbitrates load/ALU results (load wins), optionally drops
// writes to r0, buffers them in order and retires one per cycle through a
// registered register-file write port. Also answers a pending-write query.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic       clk_i,
  input  logic       reset,
  wb_queue_if.slave  bus
);

  logic [CNT_W-1:0] count;
  logic             full;
  logic             ld_fire, alu_fire;
  logic             push, pop, drop;
  wb_entry_t        sel_entry;
  wb_entry_t        head;
  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] occ;
  wb_entry_t        rd_q, rd_d;
  logic             we_q, we_d;
  logic             pend;

  // Ready is derived from registered occupancy only
  assign full            = (count == CNT_W'(DEPTH));
  assign bus.ld_ready_o  = reset & ~full;
  assign bus.alu_ready_o = reset & ~full & ~bus.ld_valid_i;

  // Fixed-priority selection of the single push for this cycle
  always_comb begin
    ld_fire   = bus.ld_valid_i & bus.ld_ready_o;
    alu_fire  = bus.alu_valid_i & bus.alu_ready_o;
    sel_entry = '{addr: bus.alu_addr_i, data: bus.alu_data_i, pos: bus.alu_pos_i};
    if (ld_fire)
      sel_entry = '{addr: bus.ld_addr_i, data: bus.ld_data_i, pos: bus.ld_pos_i};
    drop = DROP_R0 && (sel_entry.addr == '0);
    push = (ld_fire | alu_fire) & ~drop;
    pop  = (count != '0);
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (sel_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .mem_o   (mem),
    .occ_o   (occ)
  );

  // Output stage next state: load the head when popping, else hold data
  always_comb begin
    rd_d = rd_q;
    we_d = 1'b0;
    if (pop) begin
      rd_d = head;
      we_d = 1'b1;
    end
  end

  // Output stage register; data is cleared on reset so the port reads 0
  always_ff @(posedge clk_i) begin
    if (!reset) begin
      rd_q <= '0;
      we_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      we_q <= we_d;
    end
  end

  // Hazard search over live FIFO slots plus the in-flight output write
  always_comb begin
    pend = we_q && (rd_q.addr == bus.chk_addr_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (mem[i].addr == bus.chk_addr_i)) pend = 1'b1;
    end
    if (DROP_R0 && (bus.chk_addr_i == '0)) pend = 1'b0;
  end

  assign bus.RDaddr_o   = rd_q.addr;
  assign bus.RDdata_o   = rd_q.data;
  assign bus.is_pos_o   = rd_q.pos;
  assign bus.RegWrite_o = we_q;
  assign bus.chk_pend_o = pend;
  assign bus.count_o    = count;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH   = 4;
  localparam bit DROP_R0 = 1'b1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  wb_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_queue #(.DEPTH(DEPTH), .DROP_R0(DROP_R0)) dut (
    .clk_i (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffered writes in order plus the visible write port
  wb_entry_t mq[$];
  logic      m_we;
  wb_entry_t m_out;

  function automatic bit exp_ldr();
    return rst_n && (mq.size() != DEPTH);
  endfunction

  function automatic bit exp_alr();
    return rst_n && (mq.size() != DEPTH) && !bus.ld_valid_i;
  endfunction

  function automatic bit exp_pend(logic [ADDR_W-1:0] a);
    bit hit;
    hit = m_we && (m_out.addr == a);
    foreach (mq[i]) if (mq[i].addr == a) hit = 1'b1;
    if (DROP_R0 && a == '0) hit = 1'b0;
    return hit;
  endfunction

  task automatic drive_idle();
    bus.ld_valid_i  = 1'b0;
    bus.alu_valid_i = 1'b0;
  endtask

  task automatic drive_ld(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic [POS_W-1:0] p);
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = a;
    bus.ld_data_i  = d;
    bus.ld_pos_i   = p;
  endtask

  task automatic drive_alu(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic [POS_W-1:0] p);
    bus.alu_valid_i = 1'b1;
    bus.alu_addr_i  = a;
    bus.alu_data_i  = d;
    bus.alu_pos_i   = p;
  endtask

  // One clock: decide acceptance from the model, advance the model, settle
  task automatic tick();
    bit        ld_acc, al_acc;
    int        sz;
    wb_entry_t e;
    sz     = mq.size();
    ld_acc = rst_n && bus.ld_valid_i && (sz != DEPTH);
    al_acc = rst_n && bus.alu_valid_i && (sz != DEPTH) && !bus.ld_valid_i;
    if (ld_acc) e = '{addr: bus.ld_addr_i, data: bus.ld_data_i, pos: bus.ld_pos_i};
    else        e = '{addr: bus.alu_addr_i, data: bus.alu_data_i, pos: bus.alu_pos_i};
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_we  = 1'b0;
      m_out = '0;
    end else begin
      if (sz > 0) begin
        m_out = mq.pop_front();
        m_we  = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if ((ld_acc || al_acc) && !(DROP_R0 && e.addr == '0)) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.chk_addr_i = 5'd3;
    drive_ld(5'd3, 32'h1111_2222, 4'd1);
    drive_alu(5'd4, 32'h3333_4444, 4'd2);
    #1;
    checks++; if (bus.ld_ready_o !== 1'b0) $display("FAIL reset_ld_ready got=%b exp=0", bus.ld_ready_o); else passed++;
    checks++; if (bus.alu_ready_o !== 1'b0) $display("FAIL reset_alu_ready got=%b exp=0", bus.alu_ready_o); else passed++;
    tick();
    tick();
    checks++; if (bus.count_o !== '0) $display("FAIL reset_count got=%0d exp=0", bus.count_o); else passed++;
    checks++; if (bus.RegWrite_o !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.RegWrite_o); else passed++;
    checks++; if ({bus.RDaddr_o, bus.RDdata_o, bus.is_pos_o} !== '0)
      $display("FAIL reset_outs got=%h/%h/%h exp=0", bus.RDaddr_o, bus.RDdata_o, bus.is_pos_o); else passed++;
    checks++; if (bus.chk_pend_o !== 1'b0) $display("FAIL reset_pend got=%b exp=0", bus.chk_pend_o); else passed++;
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive_alu(5'd5, 32'hDEADBEEF, 4'd3);
    #1;
    checks++; if (bus.alu_ready_o !== 1'b1) $display("FAIL single_ready got=%b exp=1", bus.alu_ready_o); else passed++;
    tick();
    drive_idle();
    checks++; if (bus.count_o !== 3'd1) $display("FAIL single_count got=%0d exp=1", bus.count_o); else passed++;
    checks++; if (bus.RegWrite_o !== 1'b0) $display("FAIL single_we_early got=%b exp=0", bus.RegWrite_o); else passed++;
    tick();
    checks++; if (bus.RegWrite_o !== 1'b1) $display("FAIL single_we got=%b exp=1", bus.RegWrite_o); else passed++;
    checks++; if ({bus.RDaddr_o, bus.RDdata_o, bus.is_pos_o} !== {5'd5, 32'hDEADBEEF, 4'd3})
      $display("FAIL single_data got=%0d/%h/%0d exp=5/deadbeef/3", bus.RDaddr_o, bus.RDdata_o, bus.is_pos_o); else passed++;
    tick();
    checks++; if (bus.RegWrite_o !== 1'b0) $display("FAIL single_we_after got=%b exp=0", bus.RegWrite_o); else passed++;
    checks++; if (bus.RDdata_o !== 32'hDEADBEEF) $display("FAIL single_hold got=%h exp=deadbeef", bus.RDdata_o); else passed++;
  endtask

  task automatic test_priority();
    drive_ld(5'd7, 32'h0000_0777, 4'd1);
    drive_alu(5'd8, 32'h0000_0888, 4'd2);
    #1;
    checks++; if (bus.ld_ready_o !== 1'b1) $display("FAIL prio_ld_ready got=%b exp=1", bus.ld_ready_o); else passed++;
    checks++; if (bus.alu_ready_o !== 1'b0) $display("FAIL prio_alu_ready got=%b exp=0", bus.alu_ready_o); else passed++;
    tick();
    bus.ld_valid_i = 1'b0;
    #1;
    checks++; if (bus.alu_ready_o !== 1'b1) $display("FAIL prio_alu_ready2 got=%b exp=1", bus.alu_ready_o); else passed++;
    tick();
    drive_idle();
    checks++; if (!(bus.RegWrite_o === 1'b1 && bus.RDaddr_o === 5'd7))
      $display("FAIL prio_first got=%b/%0d exp=1/7", bus.RegWrite_o, bus.RDaddr_o); else passed++;
    tick();
    checks++; if (!(bus.RegWrite_o === 1'b1 && bus.RDaddr_o === 5'd8 && bus.RDdata_o === 32'h888))
      $display("FAIL prio_second got=%b/%0d/%h exp=1/8/888", bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o); else passed++;
    tick();
    checks++; if (bus.RegWrite_o !== 1'b0) $display("FAIL prio_done got=%b exp=0", bus.RegWrite_o); else passed++;
  endtask

  task automatic test_back_to_back();
    wb_entry_t sent[$];
    wb_entry_t got[$];
    wb_entry_t e;
    for (int i = 0; i < 5; i++) begin
      e = '{addr: 5'($urandom_range(1, 31)), data: $urandom, pos: 4'(i)};
      sent.push_back(e);
      drive_alu(e.addr, e.data, e.pos);
      #1;
      checks++; if (bus.alu_ready_o !== exp_alr())
        $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, bus.alu_ready_o, exp_alr()); else passed++;
      tick();
      if (bus.RegWrite_o === 1'b1) got.push_back('{addr: bus.RDaddr_o, data: bus.RDdata_o, pos: bus.is_pos_o});
      checks++; if (bus.count_o !== mq.size())
        $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, bus.count_o, mq.size()); else passed++;
    end
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.RegWrite_o === 1'b1) got.push_back('{addr: bus.RDaddr_o, data: bus.RDdata_o, pos: bus.is_pos_o});
    end
    checks++; if (got.size() != 5) $display("FAIL b2b_num got=%0d exp=5", got.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got.size()) $display("FAIL b2b_order i=%0d got=none exp=%h", i, sent[i]);
      else if (got[i] !== sent[i]) $display("FAIL b2b_order i=%0d got=%h exp=%h", i, got[i], sent[i]);
      else passed++;
    end
  endtask

  task automatic test_drop_r0();
    bus.chk_addr_i = 5'd0;
    drive_alu(5'd0, 32'hCAFE_F00D, 4'd9);
    #1;
    checks++; if (bus.alu_ready_o !== 1'b1) $display("FAIL r0_ready got=%b exp=1", bus.alu_ready_o); else passed++;
    tick();
    drive_idle();
    checks++; if (bus.count_o !== '0) $display("FAIL r0_count got=%0d exp=0", bus.count_o); else passed++;
    checks++; if (bus.chk_pend_o !== 1'b0) $display("FAIL r0_pend got=%b exp=0", bus.chk_pend_o); else passed++;
    tick();
    checks++; if (bus.RegWrite_o !== 1'b0) $display("FAIL r0_we got=%b exp=0", bus.RegWrite_o); else passed++;
  endtask

  task automatic test_hazard();
    bit seen;
    bus.chk_addr_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      drive_ld(5'd9, $urandom, 4'(i));
      tick();
      checks++; if (bus.chk_pend_o !== 1'b1)
        $display("FAIL haz_pend i=%0d got=%b exp=1", i, bus.chk_pend_o); else passed++;
    end
    drive_idle();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.chk_pend_o !== exp_pend(5'd9))
        $display("FAIL haz_drain i=%0d got=%b exp=%b", i, bus.chk_pend_o, exp_pend(5'd9)); else passed++;
    end
    checks++; if (bus.chk_pend_o !== 1'b0) $display("FAIL haz_clear got=%b exp=0", bus.chk_pend_o); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.chk_addr_i = 5'd12;
    for (int i = 0; i < 2; i++) begin
      drive_alu(5'd12, $urandom, 4'(i));
      tick();
    end
    drive_alu(5'd12, $urandom, 4'd2);
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.ld_ready_o, bus.alu_ready_o} !== 2'b00)
      $display("FAIL rmid_ready got=%b%b exp=00", bus.ld_ready_o, bus.alu_ready_o); else passed++;
    tick();
    checks++; if (bus.count_o !== '0) $display("FAIL rmid_count got=%0d exp=0", bus.count_o); else passed++;
    checks++; if (bus.RegWrite_o !== 1'b0) $display("FAIL rmid_we got=%b exp=0", bus.RegWrite_o); else passed++;
    checks++; if (bus.chk_pend_o !== 1'b0) $display("FAIL rmid_pend got=%b exp=0", bus.chk_pend_o); else passed++;
    drive_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.RegWrite_o !== 1'b0)
        $display("FAIL rmid_stale i=%0d got=%b exp=0", i, bus.RegWrite_o); else passed++;
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] ca;
    for (int c = 0; c < 300; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 2) == 0) drive_ld(5'($urandom_range(0, 7)), $urandom, 4'($urandom));
      else bus.ld_valid_i = 1'b0;
      if ($urandom_range(0, 1) == 0) drive_alu(5'($urandom_range(0, 7)), $urandom, 4'($urandom));
      else bus.alu_valid_i = 1'b0;
      ca = 5'($urandom_range(0, 7));
      bus.chk_addr_i = ca;
      #1;
      checks++; if ({bus.ld_ready_o, bus.alu_ready_o} !== {exp_ldr(), exp_alr()})
        $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, bus.ld_ready_o, bus.alu_ready_o, exp_ldr(), exp_alr()); else passed++;
      checks++; if (bus.chk_pend_o !== exp_pend(ca))
        $display("FAIL rand_pend c=%0d got=%b exp=%b", c, bus.chk_pend_o, exp_pend(ca)); else passed++;
      tick();
      checks++; if (bus.RegWrite_o !== m_we)
        $display("FAIL rand_we c=%0d got=%b exp=%b", c, bus.RegWrite_o, m_we); else passed++;
      checks++; if ({bus.RDaddr_o, bus.RDdata_o, bus.is_pos_o} !== m_out)
        $display("FAIL rand_out c=%0d got=%0d/%h/%0d exp=%0d/%h/%0d", c, bus.RDaddr_o, bus.RDdata_o,
                 bus.is_pos_o, m_out.addr, m_out.data, m_out.pos); else passed++;
      checks++; if (bus.count_o !== mq.size())
        $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, bus.count_o, mq.size()); else passed++;
    end
    rst_n = 1'b1;
    drive_idle();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    m_we  = 1'b0;
    m_out = '0;
    drive_idle();
    bus.ld_addr_i  = '0; bus.ld_data_i  = '0; bus.ld_pos_i  = '0;
    bus.alu_addr_i = '0; bus.alu_data_i = '0; bus.alu_pos_i = '0;
    bus.chk_addr_i = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_priority();
    test_back_to_back();
    test_drop_r0();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, %0d/%0d checks so far", passed, checks);
    $fatal(1);
  end

endmodule
